// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single-port synchronous memory behind the SLC-3 core.
// Serialises one transaction at a time and routes read data back to the port that issued it.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_mem_ena,
  output logic                  mem_wr_ena,
  output logic                  busy
);

  localparam logic [2:0] LatInit = 3'(RD_LATENCY);

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m0_rvalid_q, m0_rvalid_d;
  logic                  m1_rvalid_q, m1_rvalid_d;
  logic                  pick_m1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    // On a tie, port 1 wins only if port 0 was served last.
    pick_m1      = m1_req && (!m0_req || !last_owner_q);

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          owner_d = pick_m1;
          addr_d  = pick_m1 ? m1_addr  : m0_addr;
          wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          we_d    = pick_m1 ? m1_we    : m0_we;
          state_d = StAccess;
        end
      end
      StAccess: begin
        last_owner_d = owner_q;
        if (we_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = LatInit;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        // Counter reaching zero marks the cycle mem_rdata is valid.
        if (cnt_q == 3'd1) begin
          if (owner_q) begin
            m1_rdata_d  = mem_rdata;
            m1_rvalid_d = 1'b1;
          end else begin
            m0_rdata_d  = mem_rdata;
            m0_rvalid_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    mem_mem_ena = (state_q == StAccess);
    mem_wr_ena  = (state_q == StAccess) && we_q;
    m0_gnt      = (state_q == StAccess) && !owner_q;
    m1_gnt      = (state_q == StAccess) && owner_q;
    busy        = (state_q != StIdle);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a cycle-schedule
// model of the arbiter compared against the DUT on every negative clock edge.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata, mem_rdata, mem_addr, mem_wdata;
  logic        mem_mem_ena, mem_wr_ena, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: 256 words (addr[7:0]); unwritten words read a fixed pattern.
  logic [15:0] mem     [0:255];
  logic        written [0:255];
  logic [15:0] rd_pipe [0:LAT-1];
  logic        s_ena = 1'b0, s_we = 1'b0;
  logic [15:0] s_addr = '0, s_wdata = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (written[a[7:0]] === 1'b1) return mem[a[7:0]];
    if (a == 16'h4010) return 16'h1234;
    return a ^ 16'h5A5A;
  endfunction

  always @(negedge clk) begin
    s_ena   <= mem_mem_ena;
    s_we    <= mem_wr_ena;
    s_addr  <= mem_addr;
    s_wdata <= mem_wdata;
  end

  always @(posedge clk) begin
    if (s_ena && s_we) begin
      mem[s_addr[7:0]]     <= s_wdata;
      written[s_addr[7:0]] <= 1'b1;
    end
    rd_pipe[0] <= (s_ena && !s_we) ? mem_word(s_addr) : 16'h0000;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Model: schedule of grant / rvalid cycles and when the arbiter is idle again.
  int          cyc = 0;
  int          idle_from = 0, gnt_cyc = -1, rv_cyc = -1;
  logic        gnt_port = 1'b0, rv_port = 1'b0, cmd_we = 1'b0, last_owner = 1'b1;
  logic [15:0] cmd_addr = '0, cmd_wdata = '0, rv_data = '0, exp_rd0 = '0, exp_rd1 = '0;
  logic        win;
  logic [15:0] win_addr, win_wdata;
  logic        win_we;

  assign win       = (m0_req && m1_req) ? ~last_owner : m1_req;
  assign win_addr  = win ? m1_addr  : m0_addr;
  assign win_wdata = win ? m1_wdata : m0_wdata;
  assign win_we    = win ? m1_we    : m0_we;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      idle_from  <= 0;
      gnt_cyc    <= -1;
      rv_cyc     <= -1;
      last_owner <= 1'b1;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_we     <= 1'b0;
      exp_rd0    <= '0;
      exp_rd1    <= '0;
    end else begin
      if (cyc + 1 == rv_cyc) begin
        if (rv_port) exp_rd1 <= rv_data;
        else         exp_rd0 <= rv_data;
      end
      if (cyc >= idle_from && (m0_req || m1_req)) begin
        gnt_cyc    <= cyc + 1;
        gnt_port   <= win;
        last_owner <= win;
        cmd_addr   <= win_addr;
        cmd_wdata  <= win_wdata;
        cmd_we     <= win_we;
        if (win_we) begin
          idle_from <= cyc + 2;
        end else begin
          rv_cyc    <= cyc + 2 + LAT;
          rv_port   <= win;
          rv_data   <= mem_word(win_addr);
          idle_from <= cyc + 2 + LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs",
          {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_mem_ena, mem_wr_ena, busy, mem_addr,
           mem_wdata}, 64'd0);
    end else begin
      chk("model_ctl",
          {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_mem_ena, mem_wr_ena, busy},
          {(cyc == gnt_cyc) && !gnt_port, (cyc == gnt_cyc) && gnt_port,
           (cyc == rv_cyc) && !rv_port, (cyc == rv_cyc) && rv_port,
           cyc == gnt_cyc, (cyc == gnt_cyc) && cmd_we, cyc < idle_from});
      chk("model_bus", {mem_addr, mem_wdata}, {cmd_addr, cmd_wdata});
      chk("model_rdata", {m0_rdata, m1_rdata}, {exp_rd0, exp_rd1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] b2b_data [0:2];
  logic [1:0]  fair_seq [0:7];

  initial begin
    b2b_data = '{16'h1111, 16'h2222, 16'h3333};
    fair_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    repeat (3) tick();
    chk("lit_reset_idle", {busy, mem_mem_ena, m0_rdata, m1_rdata}, 34'd0);
    reset = 1'b1;
    tick();

    // Reset during WAIT of a port 0 read.
    m0_we = 1'b0; m0_addr = 16'h3000; m0_req = 1'b1;
    tick();
    chk("rst_rd_gnt", m0_gnt, 1'b1);
    m0_req = 1'b0;
    tick();
    chk("rst_rd_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_async", {mem_mem_ena, busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 6'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    end
    m0_req = 1'b1;
    tick();
    chk("rd0_gnt", m0_gnt, 1'b1);
    m0_req = 1'b0;
    tick();
    tick();
    chk("rd0_early", m0_rvalid, 1'b0);
    tick();
    chk("rd0_rvalid", {m0_rvalid, m0_rdata}, {1'b1, 16'h6A5A});
    tick();
    chk("rd0_pulse", m0_rvalid, 1'b0);

    // Port 0 write.
    m0_we = 1'b1; m0_addr = 16'h3000; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    tick();
    chk("wr_bus", {mem_mem_ena, mem_wr_ena, mem_addr, mem_wdata, m0_gnt, m1_gnt},
        {2'b11, 16'h3000, 16'hBEEF, 2'b10});
    m0_req = 1'b0;
    tick();
    chk("wr_idle", busy, 1'b0);

    // Port 1 read with latency 2.
    m1_we = 1'b0; m1_addr = 16'h4010; m1_req = 1'b1;
    tick();
    chk("rd1_gnt", {m1_gnt, m0_gnt}, 2'b10);
    m1_req = 1'b0;
    tick();
    tick();
    chk("rd1_early", m1_rvalid, 1'b0);
    tick();
    chk("rd1_rvalid", {m1_rvalid, m1_rdata}, {1'b1, 16'h1234});
    chk("rd1_port0_quiet", {m0_rvalid, m0_rdata}, {1'b0, 16'h6A5A});
    tick();

    // Fairness: both hold write requests from reset release.
    reset = 1'b0;
    m0_we = 1'b1; m0_addr = 16'h0020; m0_wdata = 16'hA0A0;
    m1_we = 1'b1; m1_addr = 16'h0021; m1_wdata = 16'hB1B1;
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fair_order", {m1_gnt, m0_gnt}, fair_seq[i]);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();

    // Back-to-back port 0 writes.
    m0_we = 1'b1; m0_addr = 16'h0050; m0_wdata = b2b_data[0]; m0_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("b2b_gnt", {m0_gnt, mem_wdata}, {1'b1, b2b_data[i/2]});
        if (i < 4) begin
          m0_addr  = m0_addr + 16'd1;
          m0_wdata = b2b_data[i/2 + 1];
        end else begin
          m0_req = 1'b0;
        end
      end else begin
        chk("b2b_gap", m0_gnt, 1'b0);
      end
    end
    tick();

    // Port 1 request pulsed only during a port 0 ACCESS.
    m0_we = 1'b1; m0_addr = 16'h0060; m0_wdata = 16'h6666; m0_req = 1'b1;
    tick();
    chk("drop_m0_gnt", m0_gnt, 1'b1);
    m0_req = 1'b0;
    m1_we = 1'b0; m1_addr = 16'h0070; m1_req = 1'b1;
    tick();
    m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_no_m1", {m1_gnt, mem_mem_ena, mem_addr}, {2'b00, 16'h0060});
      tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
